int_seq: RTL and testbench
==========================

# int_seq

Parametrised interrupt sequencer for the pipelined MIPS core. It generalises the single counter-interrupt / `rti` path to `NCH` prioritised channels, with per-channel masking and edge/level mode, plus nested entry up to `NEST` levels through an internal EPC/priority stack. It sits beside the controller in decode and drives the redirect, flush and `branch_stall_F` contribution, replacing the lone `int_en1`.

## Interface
- `NCH`, 4: number of interrupt channels. Channel 0 has the highest priority.
- `NEST`, 2: maximum nesting depth (stack entries), ≥1.
- `PC_W`, 32: PC/vector width.
- `VEC_BASE`, 32'h0000_0180: vector of channel 0.
- `VEC_STRIDE`, 32'h0000_0020: vector spacing per channel.
- `EDGE_MASK`, {NCH{1'b1}}: bit i=1 makes channel i rising-edge; 0 makes it level.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `irq` in NCH: raw requests, already synchronous to `clk`.
- `mask_we` in 1: write the enable mask (counter-interrupt-class instruction in decode).
- `mask_wdata` in NCH: new enable mask; 1 = enabled.
- `stallD` in 1: decode stalled.
- `is_branch_or_jmp_D` in 1: decode holds a branch/jump (delay slot follows).
- `rtiD` in 1: decode holds `rti` (opcode 110000).
- `pcD` in PC_W: PC of the decode instruction.
- `take_int` out 1: one-cycle pulse; redirect to `vec_pc`, flush E.
- `vec_pc` out PC_W: `VEC_BASE + ch*VEC_STRIDE`; valid with `take_int`.
- `rti_take` out 1: one-cycle pulse; redirect to `ret_pc`.
- `ret_pc` out PC_W: popped EPC; valid with `rti_take`.
- `depth` out clog2(NEST+1): current nesting depth.
- `cur_ch` out clog2(NCH): channel being serviced; 0 when depth=0.
- `pending` out NCH: latched pending vector.
- `int_stall_F` out 1: equals `take_int | rti_take`; ORed into `branch_stall_F`.

## Operation
**Pending**
- Edge channel i: set on `irq[i] & ~irq_q[i]`; cleared on the cycle its `take_int` is issued.
- Level channel i: `pending[i] = irq[i]`, never latched. The device must drop `irq` inside its handler.
- Set and clear in the same cycle: set wins.

**Mask and priority**
- Eligible = `pending & mask & prio_allow`.
- `prio_allow` enables only channels strictly below `cur_ch` when depth>0; all channels when depth=0.
- Winner = lowest eligible index.

**Safe point**
- `safe = ~stallD & ~is_branch_or_jmp_D & ~rtiD`.
- Interrupts are never taken on a delay slot or an `rti`.

**States**
- IDLE
  - eligible≠0 and safe and depth<NEST → TAKE.
  - `rtiD & ~stallD` and depth>0 → RET.
  - `rtiD` with depth=0: ignored, no pulse.
- TAKE (1 cycle)
  - `take_int=1`; push {`pcD`, previous `cur_ch`}; depth+1; `cur_ch`=winner.
  - Clear the winner's edge pending.
  - Return to IDLE.
- RET (1 cycle)
  - `rti_take=1`; `ret_pc`=stack top EPC.
  - Pop; restore `cur_ch`; depth−1.
  - Return to IDLE.

**Boundary cases**
- `rtiD` and eligible in the same cycle: RET (the safe point is false).
- depth=NEST: no take; pending is held.
- `mask_we` during TAKE: affects eligibility from the next cycle only.
- Mask write clearing a pending-but-masked channel: pending is retained.
- Stack overflow is impossible by construction.

## Timing
- Reset values: state IDLE; `take_int=0`, `rti_take=0`, `int_stall_F=0`; `depth=0`, `cur_ch=0`; `pending=0`; `mask=0` (all disabled); `irq_q=0`; stack entries 0; `vec_pc=VEC_BASE`, `ret_pc=0`.
- Latency from `irq` edge to `take_int`:
  - Edge channel: 2 cycles (edge detected at cycle 1, pending registered; evaluate and take at cycle 2).
  - Level channel: 1 cycle.
- Both are stretched by unsafe cycles.
- `take_int`, `rti_take` and `vec_pc`/`ret_pc` are registered outputs.
- Back-to-back TAKE is impossible; at least one IDLE cycle separates pulses.
- Reset mid-TAKE/RET: immediate return to reset values; stack discarded.

## Structure
- Shared package `int_pkg`:
  - state enum {IDLE, TAKE, RET};
  - `VEC_BASE`/`VEC_STRIDE` defaults;
  - typedef `stack_entry_t` {epc, ch}.
- One sub-module, `prio_enc #(NCH)`: combinational lowest-index encoder with a valid output.

## Test plan
- Reset; `mask=4'b1111`; rising edge on `irq[2]` at cycle 10, safe → `take_int` at cycle 12; `vec_pc=32'h1C0`; depth 1; `cur_ch=2`.
- In handler (depth 1, ch 2), `irq[0]` edge → nested take, `vec_pc=32'h180`, depth 2. A concurrent `irq[3]` edge stays pending (lower priority).
- With depth 2 (`NEST`=2), `irq[1]` pending → no take until `rti`. `rti` → `rti_take`, `ret_pc`=EPC pushed for ch 0; ch 1 is then taken (1 < `cur_ch`=2).
- `is_branch_or_jmp_D=1` for 3 cycles while ch 1 is pending → `take_int` delayed until the first safe cycle. `pcD` captured there and returned exactly by the matching `rti`.
- Level channel 3 (`EDGE_MASK=4'b0111`), `mask[3]=0`, `irq[3]` held → no take. Write `mask=4'b1000` → take 1 cycle after the write.
- `reset` asserted low during RET → all outputs return to reset values in the same cycle; stack and depth are zero afterwards.

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared types and defaults for the interrupt sequencer: FSM states, vector
// defaults and the EPC/priority stack entry.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    RET
  } state_e;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0180;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

  // Stack fields are sized for the widest supported configuration.
  localparam int EPC_W    = 32;
  localparam int CH_W_MAX = 8;

  typedef struct packed {
    logic [EPC_W-1:0]    epc;
    logic [CH_W_MAX-1:0] ch;
  } stack_entry_t;

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/int_seq_if.sv
// Decode-side request/redirect bundle between the core and the interrupt
// sequencer; the core is the master, the sequencer the slave.
interface int_seq_if #(
  parameter int NCH  = 4,
  parameter int NEST = 2,
  parameter int PC_W = 32
);
  import int_pkg::*;

  localparam int CH_W    = ch_width(NCH);
  localparam int DEPTH_W = $clog2(NEST + 1);

  logic [NCH-1:0]     irq;
  logic               mask_we;
  logic [NCH-1:0]     mask_wdata;
  logic               stallD;
  logic               is_branch_or_jmp_D;
  logic               rtiD;
  logic [PC_W-1:0]    pcD;

  logic               take_int;
  logic [PC_W-1:0]    vec_pc;
  logic               rti_take;
  logic [PC_W-1:0]    ret_pc;
  logic [DEPTH_W-1:0] depth;
  logic [CH_W-1:0]    cur_ch;
  logic [NCH-1:0]     pending;
  logic               int_stall_F;

  modport master (
    output irq, mask_we, mask_wdata, stallD, is_branch_or_jmp_D, rtiD, pcD,
    input  take_int, vec_pc, rti_take, ret_pc, depth, cur_ch, pending, int_stall_F
  );

  modport slave (
    input  irq, mask_we, mask_wdata, stallD, is_branch_or_jmp_D, rtiD, pcD,
    output take_int, vec_pc, rti_take, ret_pc, depth, cur_ch, pending, int_stall_F
  );

endinterface

// File: rtl/int_seq_prio_enc.sv
// Lowest-index-wins priority encoder; valid_o flags that any request is set.
module prio_enc
  import int_pkg::*;
#(
  parameter int  NCH  = 4,
  localparam int CH_W = ch_width(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  output logic [CH_W-1:0] idx_o,
  output logic            valid_o
);

  // NOTE: a combinational output must be given a value on every path before
  // any conditional update, otherwise synthesis infers a latch.
  always_comb begin
    idx_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = CH_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/int_seq.sv
// Prioritised, maskable, nestable interrupt sequencer for the decode stage:
// picks a channel at a safe point, redirects to its vector and unwinds on rti.
module int_seq
  import int_pkg::*;
#(
  parameter int              NCH        = 4,
  parameter int              NEST       = 2,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(VEC_BASE_DEF),
  parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(VEC_STRIDE_DEF),
  parameter logic [NCH-1:0]  EDGE_MASK  = {NCH{1'b1}}
) (
  input  logic      clk,
  input  logic      reset,
  int_seq_if.slave  bus
);

  localparam int                 CH_W    = ch_width(NCH);
  localparam int                 DEPTH_W = $clog2(NEST + 1);
  localparam logic [DEPTH_W-1:0] NEST_D  = DEPTH_W'(NEST);

  state_e             state_q, state_d;
  logic [NCH-1:0]     irq_q;
  logic [NCH-1:0]     edge_pend_q, edge_pend_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic               take_int_q, take_int_d;
  logic               rti_take_q, rti_take_d;
  logic [PC_W-1:0]    vec_pc_q, vec_pc_d;
  logic [PC_W-1:0]    ret_pc_q, ret_pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  stack_entry_t       stack_q [NEST];
  stack_entry_t       stack_d [NEST];

  logic [NCH-1:0]     rise, pending, prio_allow, eligible, clr;
  logic [CH_W-1:0]    win_ch;
  logic               win_valid;
  logic               safe;
  stack_entry_t       top;

  // Level channels follow irq directly; only edge channels are latched.
  assign rise     = bus.irq & ~irq_q & EDGE_MASK;
  assign pending  = (edge_pend_q & EDGE_MASK) | (bus.irq & ~EDGE_MASK);
  assign eligible = pending & mask_q & prio_allow;
  assign safe     = ~bus.stallD & ~bus.is_branch_or_jmp_D & ~bus.rtiD;
  assign mask_d   = bus.mask_we ? bus.mask_wdata : mask_q;

  always_comb begin
    prio_allow = '0;
    for (int i = 0; i < NCH; i++) begin
      prio_allow[i] = (depth_q == '0) || (CH_W'(i) < cur_ch_q);
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < NEST; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) top = stack_q[i];
    end
  end

  prio_enc #(.NCH(NCH)) u_prio_enc (
    .req_i   (eligible),
    .idx_o   (win_ch),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d    = IDLE;
    take_int_d = 1'b0;
    rti_take_d = 1'b0;
    vec_pc_d   = vec_pc_q;
    ret_pc_d   = ret_pc_q;
    depth_d    = depth_q;
    cur_ch_d   = cur_ch_q;
    stack_d    = stack_q;
    clr        = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid && safe && (depth_q < NEST_D)) begin
          state_d    = TAKE;
          take_int_d = 1'b1;
          vec_pc_d   = VEC_BASE + PC_W'(win_ch) * VEC_STRIDE;
          for (int i = 0; i < NEST; i++) begin
            if (depth_q == DEPTH_W'(i)) begin
              stack_d[i].epc = EPC_W'(bus.pcD);
              stack_d[i].ch  = CH_W_MAX'(cur_ch_q);
            end
          end
          depth_d  = depth_q + 1'b1;
          cur_ch_d = win_ch;
          clr      = NCH'(1) << win_ch;
        end else if (bus.rtiD && !bus.stallD && (depth_q != '0)) begin
          state_d    = RET;
          rti_take_d = 1'b1;
          ret_pc_d   = PC_W'(top.epc);
          cur_ch_d   = CH_W'(top.ch);
          depth_d    = depth_q - 1'b1;
        end
      end
      TAKE, RET: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A new edge in the same cycle as the take of that channel keeps it pending.
  assign edge_pend_d = (edge_pend_q & ~clr) | rise;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      edge_pend_q <= '0;
      mask_q      <= '0;
      take_int_q  <= 1'b0;
      rti_take_q  <= 1'b0;
      vec_pc_q    <= VEC_BASE;
      ret_pc_q    <= '0;
      depth_q     <= '0;
      cur_ch_q    <= '0;
      // NOTE: the stack is small and must read as zero after reset, so it is
      // built from resettable flops rather than an inferred RAM.
      for (int i = 0; i < NEST; i++) stack_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= bus.irq;
      edge_pend_q <= edge_pend_d;
      mask_q      <= mask_d;
      take_int_q  <= take_int_d;
      rti_take_q  <= rti_take_d;
      vec_pc_q    <= vec_pc_d;
      ret_pc_q    <= ret_pc_d;
      depth_q     <= depth_d;
      cur_ch_q    <= cur_ch_d;
      stack_q     <= stack_d;
    end
  end

  assign bus.take_int    = take_int_q;
  assign bus.rti_take    = rti_take_q;
  assign bus.vec_pc      = vec_pc_q;
  assign bus.ret_pc      = ret_pc_q;
  assign bus.depth       = depth_q;
  assign bus.cur_ch      = cur_ch_q;
  assign bus.pending     = pending;
  assign bus.int_stall_F = take_int_q | rti_take_q;

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: 4 channels (ch3 level), nesting depth 2.
module tb_int_seq;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  int_seq_if #(.NCH(4), .NEST(2), .PC_W(32)) bus ();

  int_seq #(
    .NCH       (4),
    .NEST      (2),
    .PC_W      (32),
    .EDGE_MASK (4'b0111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_take"},    32'(bus.take_int),    32'd0);
    check({tag, "_rti"},     32'(bus.rti_take),    32'd0);
    check({tag, "_stall"},   32'(bus.int_stall_F), 32'd0);
    check({tag, "_depth"},   32'(bus.depth),       32'd0);
    check({tag, "_cur_ch"},  32'(bus.cur_ch),      32'd0);
    check({tag, "_pending"}, 32'(bus.pending),     32'd0);
    check({tag, "_vec_pc"},  bus.vec_pc,           32'h180);
    check({tag, "_ret_pc"},  bus.ret_pc,           32'h0);
  endtask

  initial begin
    reset                  = 1'b1;
    bus.irq                = '0;
    bus.mask_we            = 1'b0;
    bus.mask_wdata         = '0;
    bus.stallD             = 1'b0;
    bus.is_branch_or_jmp_D = 1'b0;
    bus.rtiD               = 1'b0;
    bus.pcD                = '0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("rst");
    step();
    step();
    reset = 1'b1;

    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
    step();
    bus.mask_we = 1'b0;
    repeat (6) step();

    // Edge on ch2: pending one cycle later, take the cycle after.
    bus.irq = 4'b0100; bus.pcD = 32'h400;
    step();
    check("ch2_pend",      32'(bus.pending),  32'b0100);
    check("ch2_no_take_1", 32'(bus.take_int), 32'd0);
    step();
    check("ch2_take",      32'(bus.take_int),    32'd1);
    check("ch2_vec",       bus.vec_pc,           32'h1C0);
    check("ch2_depth",     32'(bus.depth),       32'd1);
    check("ch2_cur",       32'(bus.cur_ch),      32'd2);
    check("ch2_stall",     32'(bus.int_stall_F), 32'd1);
    check("ch2_pend_clr",  32'(bus.pending),     32'b0000);
    bus.irq = 4'b0000;
    step();
    check("ch2_pulse_end", 32'(bus.take_int), 32'd0);

    // Nested ch0 preempts ch2; level ch3 stays pending (lower priority).
    bus.irq = 4'b1001; bus.pcD = 32'h500;
    step();
    check("nest_pend",  32'(bus.pending),  32'b1001);
    check("nest_wait",  32'(bus.take_int), 32'd0);
    step();
    check("nest_take",  32'(bus.take_int), 32'd1);
    check("nest_vec",   bus.vec_pc,        32'h180);
    check("nest_depth", 32'(bus.depth),    32'd2);
    check("nest_cur",   32'(bus.cur_ch),   32'd0);
    check("nest_pend2", 32'(bus.pending),  32'b1000);

    // Depth full: ch1 edge is held pending.
    bus.irq = 4'b1010;
    step();
    check("full_pend",  32'(bus.pending),  32'b1010);
    step();
    check("full_take",  32'(bus.take_int), 32'd0);
    check("full_depth", 32'(bus.depth),    32'd2);
    check("full_hold",  32'(bus.pending),  32'b1010);

    bus.rtiD = 1'b1; bus.pcD = 32'h504;
    step();
    check("rti1_take",  32'(bus.rti_take),    32'd1);
    check("rti1_pc",    bus.ret_pc,           32'h500);
    check("rti1_depth", 32'(bus.depth),       32'd1);
    check("rti1_cur",   32'(bus.cur_ch),      32'd2);
    check("rti1_stall", 32'(bus.int_stall_F), 32'd1);

    // Branch/delay-slot window delays the ch1 take until the first safe cycle.
    bus.rtiD = 1'b0; bus.is_branch_or_jmp_D = 1'b1; bus.pcD = 32'h5F0;
    step();
    check("br_take_0", 32'(bus.take_int), 32'd0);
    check("br_rti_0",  32'(bus.rti_take), 32'd0);
    bus.pcD = 32'h5F4;
    step();
    check("br_take_1", 32'(bus.take_int), 32'd0);
    bus.pcD = 32'h5F8;
    step();
    check("br_take_2", 32'(bus.take_int), 32'd0);
    bus.is_branch_or_jmp_D = 1'b0; bus.pcD = 32'h600;
    step();
    check("ch1_take",  32'(bus.take_int), 32'd1);
    check("ch1_vec",   bus.vec_pc,        32'h1A0);
    check("ch1_depth", 32'(bus.depth),    32'd2);
    check("ch1_cur",   32'(bus.cur_ch),   32'd1);
    check("ch1_pend",  32'(bus.pending),  32'b1000);
    step();
    check("ch1_pulse_end", 32'(bus.take_int), 32'd0);

    bus.rtiD = 1'b1;
    step();
    check("rti2_take",  32'(bus.rti_take), 32'd1);
    check("rti2_pc",    bus.ret_pc,        32'h600);
    check("rti2_depth", 32'(bus.depth),    32'd1);
    check("rti2_cur",   32'(bus.cur_ch),   32'd2);
    bus.rtiD = 1'b0;
    step();
    check("ch3_blocked", 32'(bus.take_int), 32'd0);
    check("ch3_pend",    32'(bus.pending),  32'b1000);
    bus.rtiD = 1'b1;
    step();
    check("rti3_take",  32'(bus.rti_take), 32'd1);
    check("rti3_pc",    bus.ret_pc,        32'h400);
    check("rti3_depth", 32'(bus.depth),    32'd0);
    check("rti3_cur",   32'(bus.cur_ch),   32'd0);
    bus.rtiD = 1'b0; bus.irq = 4'b0000;
    step();
    check("rti3_pulse_end", 32'(bus.rti_take), 32'd0);

    // rti with nothing to return from is ignored.
    bus.rtiD = 1'b1;
    step();
    check("rti0_ignored", 32'(bus.rti_take), 32'd0);
    check("rti0_depth",   32'(bus.depth),    32'd0);

    // Level ch3 masked off, then enabled by a mask write.
    bus.rtiD = 1'b0; bus.mask_we = 1'b1; bus.mask_wdata = 4'b0111;
    step();
    bus.mask_we = 1'b0; bus.irq = 4'b1000;
    step();
    check("lvl_pend",     32'(bus.pending),  32'b1000);
    check("lvl_masked_0", 32'(bus.take_int), 32'd0);
    step();
    check("lvl_masked_1", 32'(bus.take_int), 32'd0);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1000;
    step();
    check("lvl_wr_cycle", 32'(bus.take_int), 32'd0);
    bus.mask_we = 1'b0;
    step();
    check("lvl_take",  32'(bus.take_int), 32'd1);
    check("lvl_vec",   bus.vec_pc,        32'h1E0);
    check("lvl_depth", 32'(bus.depth),    32'd1);
    check("lvl_cur",   32'(bus.cur_ch),   32'd3);

    // Masked edge pending on ch2 survives a mask write that leaves it disabled.
    bus.irq = 4'b0100;
    step();
    check("mpend_set",  32'(bus.pending),  32'b0100);
    step();
    check("mpend_wait", 32'(bus.take_int), 32'd0);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0000;
    step();
    check("mpend_kept", 32'(bus.pending),  32'b0100);
    bus.mask_wdata = 4'b0100; bus.pcD = 32'h700;
    step();
    check("mpend_no_take", 32'(bus.take_int), 32'd0);
    check("mpend_kept2",   32'(bus.pending),  32'b0100);
    bus.mask_we = 1'b0;
    step();
    check("mpend_take",  32'(bus.take_int), 32'd1);
    check("mpend_vec",   bus.vec_pc,        32'h1C0);
    check("mpend_depth", 32'(bus.depth),    32'd2);
    check("mpend_cur",   32'(bus.cur_ch),   32'd2);
    check("mpend_clr",   32'(bus.pending),  32'b0000);
    step();

    // Reset asserted while rti_take is high.
    bus.rtiD = 1'b1;
    step();
    check("rti4_take",  32'(bus.rti_take), 32'd1);
    check("rti4_pc",    bus.ret_pc,        32'h700);
    check("rti4_depth", 32'(bus.depth),    32'd1);
    check("rti4_cur",   32'(bus.cur_ch),   32'd3);
    reset = 1'b0; bus.rtiD = 1'b0; bus.irq = 4'b0000;
    #1;
    check_reset_outputs("midret");
    step();
    step();
    reset = 1'b1;
    bus.rtiD = 1'b1;
    step();
    check("post_rti_ignored", 32'(bus.rti_take), 32'd0);
    check("post_depth",       32'(bus.depth),    32'd0);
    bus.rtiD = 1'b0; bus.irq = 4'b0001;
    step();
    check("post_pend", 32'(bus.pending), 32'b0001);
    step();
    check("post_mask_off", 32'(bus.take_int), 32'd0);
    check("post_depth2",   32'(bus.depth),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
